// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b, one 4-bit carry-lookahead nibble per clock, LSB first.
// Valid/ready on both sides; result registers hold their value after the output handshake.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, both decoded from state.

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             borrow_q, ovf_q;

  logic [CW+1:0]    base;
  logic [3:0]       an, bn, g, p, dnib;
  logic             c0, c1, c2, c3;
  logic             last;

  // Nibble slice on a + ~b + carry_in, carries fully expanded (lookahead)
  always_comb begin
    base = {cnt, 2'b00};
    an   = a_q[base +: 4];
    bn   = b_q[base +: 4];
    g    = an & ~bn;
    p    = an ^ ~bn;
    c0   = g[0] | (p[0] & carry);
    c1   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c2   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    c3   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & carry);
    dnib = p ^ {c2, c1, c0, carry};
    last = (cnt == CW'(NIB - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          cnt   <= '0;
          carry <= 1'b1;
        end
        CALC: begin
          diff_q[base +: 4] <= dnib;
          carry             <= c3;
          cnt               <= cnt + CW'(1);
          // dnib[3] is the result sign bit on the final nibble
          if (last) begin
            borrow_q <= ~c3;
            ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dnib[3] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor (WIDTH=16): latency, arithmetic corners,
// backpressure, busy input and mid-operation reset, with hand-computed expectations.
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accept edge, then count edges until out_valid (bounded).
  task automatic start_and_wait(input logic [15:0] av, input logic [15:0] bv,
                                input string name, output int edges);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready_before_accept: got %b want 1", name, in_ready);
    end
    a = av; b = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    edges = 0;
    while (out_valid !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    n_checks++;
    if (edges !== 4) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges want 4", name, edges);
    end
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ed, input logic eb, input logic eo,
                        input string name);
    int edges;
    start_and_wait(av, bv, name, edges);
    n_checks++;
    if (diff !== ed) begin
      n_fail++;
      $display("FAIL %s diff: got %h want %h", name, diff, ed);
    end
    n_checks++;
    if (borrow !== eb) begin
      n_fail++;
      $display("FAIL %s borrow: got %b want %b", name, borrow, eb);
    end
    n_checks++;
    if (ovf !== eo) begin
      n_fail++;
      $display("FAIL %s ovf: got %b want %b", name, ovf, eo);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick();
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    n_checks++;
    if (diff !== 16'h0000 || borrow !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got diff=%h borrow=%b ovf=%b want 0000/0/0", diff, borrow, ovf);
    end
  endtask

  task automatic test_basic();
    run_op(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_underflow();
    run_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, "underflow");
    run_op(16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0, "equal");
  endtask

  task automatic test_overflow();
    run_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, "ovf_neg");
    run_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, "ovf_pos");
  endtask

  task automatic test_backpressure();
    int edges;
    start_and_wait(16'h4321, 16'h1234, "backpressure", edges);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || diff !== 16'h30ED || borrow !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold cycle %0d: got out_valid=%b diff=%h borrow=%b want 1/30ed/0",
                 i, out_valid, diff, borrow);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    n_checks++;
    if (diff !== 16'h30ED) begin
      n_fail++;
      $display("FAIL backpressure_diff_kept: got %h want 30ed", diff);
    end
  endtask

  task automatic test_busy_input();
    int edges;
    a = 16'h5678; b = 16'h1234; in_valid = 1'b1;
    tick();
    a = 16'hFFFF; b = 16'h0000;
    edges = 0;
    while (out_valid !== 1'b1 && edges < 20) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_in_ready edge %0d: got %b want 0", edges, in_ready);
      end
      tick();
      edges++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (edges !== 4 || diff !== 16'h4444 || borrow !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_result: got edges=%0d diff=%h borrow=%b ovf=%b want 4/4444/0/0",
               edges, diff, borrow, ovf);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h4444) begin
        n_fail++;
        $display("FAIL busy_not_captured: got in_ready=%b out_valid=%b diff=%h want 1/0/4444",
                 in_ready, out_valid, diff);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    a = 16'h1234; b = 16'h0234; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || diff !== 16'h0000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_state: got out_valid=%b diff=%h in_ready=%b want 0/0000/1",
               out_valid, diff, in_ready);
    end
    n_checks++;
    if (borrow !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_flags: got borrow=%b ovf=%b want 0/0", borrow, ovf);
    end
    run_op(16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, "b2b_0");
    run_op(16'hFFFF, 16'h8000, 16'h7FFF, 1'b0, 1'b0, "b2b_1");
    run_op(16'h0001, 16'h8000, 16'h8001, 1'b1, 1'b1, "b2b_2");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_overflow();
    test_backpressure();
    test_busy_input();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
